sample1_monitor: RTL and testbench
==================================

SAMPLE1_MONITOR -- requirements
Module: sample1_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, expected-value buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter NUM_SAMPLES, default 16, observed samples per run (1..255).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  run control pulse.
REQ-006 SHALL have ports exp_valid in 1, exp_data in 2, exp_ready out 1  golden Y1 values, valid/ready handshake.
REQ-007 SHALL have ports obs_valid in 1, A1 in 2, A2 in 2, A3 in 2, Y1 in 2  observed stimulus/response of sample1 under test.
REQ-008 SHALL have ports busy out 1, done out 1, pass out 1, underrun out 1  status.
REQ-009 SHALL have ports smp_cnt out 8, err_cnt out 8, first_err out 8  counters and first-mismatch record {A1,A2,A3,Y1}.

Function
REQ-010 SHALL implement FSM IDLE, RUN, DONE: IDLE--start-->RUN; RUN--(smp_cnt reaches NUM_SAMPLES)-->DONE; DONE--start-->IDLE; start ignored in RUN.
REQ-011 SHALL clear smp_cnt, err_cnt, first_err and underrun on the IDLE->RUN edge; FIFO contents kept, allowing preload in IDLE.
REQ-012 SHALL flush the FIFO on the DONE->IDLE edge; counters hold their values throughout DONE for readout.
REQ-013 SHALL drive exp_ready = (FIFO occupancy < DEPTH) and state != DONE, derived from registered occupancy only; no combinational path from obs_valid.
REQ-014 SHALL push exp_data when exp_valid and exp_ready are both high in the same cycle, in IDLE or RUN.
REQ-015 SHALL treat obs_valid in RUN as one sample: smp_cnt += 1; if the FIFO is non-empty, pop the head and compare with Y1; if the FIFO is empty, set underrun (sticky) and count an error.
REQ-016 SHALL increment err_cnt on every mismatch or underrun sample; err_cnt saturates at 255.
REQ-017 SHALL load first_err = {A1,A2,A3,Y1} on the first erroring sample of a run only.
REQ-018 SHALL NOT bypass from write to read: a push and an obs_valid in the same cycle on an empty FIFO yield an underrun, and the pushed value remains stored.
REQ-019 SHALL allow a simultaneous push and pop on a non-full FIFO, leaving occupancy unchanged; FIFO pointers wrap modulo DEPTH.
REQ-020 SHALL ignore obs_valid in IDLE and DONE: no pop and no counter change.
REQ-021 SHALL enter DONE on the cycle after the NUM_SAMPLES-th sample is accepted; later obs_valid pulses are ignored.
REQ-022 SHALL drive busy = (state==RUN), done = (state==DONE), and pass = done and err_cnt==0 and !underrun, all registered or decoded from registered state.

Reset
REQ-023 SHALL, when rst is high at a clock edge, force state=IDLE, FIFO empty, and all counters and flags to 0, including mid-run; rst overrides start and both handshakes in the same cycle.
REQ-024 SHALL hold output values after reset of busy=0, done=0, pass=0, underrun=0, smp_cnt=0, err_cnt=0, first_err=0, exp_ready=1.

Structure
REQ-025 SHALL place the FSM state enum, the counter width constant (8) and the sample record width (8) in shared package sample1_pkg.
REQ-026 SHALL implement the buffer as sub-module sample1_exp_fifo (synchronous, DEPTH entries of 2 bits, push/pop/flush, full/empty/count).
REQ-027 SHALL target 120-400 lines of RTL with no latches and no clock gating.

Verification
REQ-028 SHALL cover: preload 16 values in IDLE (exp_ready drops after 4), start, 16 matching samples paced with refills -> done=1, pass=1, err_cnt=0, smp_cnt=16.
REQ-029 SHALL cover: expected 3, observe Y1=1 with A1=1,A2=3,A3=0 as the 2nd sample, all other samples match -> err_cnt=1, first_err=8'h71, pass=0.
REQ-030 SHALL cover: start with an empty FIFO, obs_valid asserted together with exp_valid -> underrun=1, err_cnt=1, pushed value popped by the next sample.
REQ-031 SHALL cover: FIFO full, exp_valid plus obs_valid in the same cycle -> exp_ready=0, no push, occupancy 3.
REQ-032 SHALL cover: rst pulsed after sample 5 -> next cycle busy=0, smp_cnt=0, exp_ready=1, a fresh run completes normally.
REQ-033 SHALL cover: 20 obs_valid pulses in a 16-sample run, then start in DONE -> smp_cnt stays 16, IDLE entered, FIFO flushed.

Source files
------------

// File: rtl/sample1_pkg.sv
// Shared definitions for the sample1 response monitor.
//   CNT_W   : width of the sample and error counters
//   REC_W   : width of the first-mismatch record {A1,A2,A3,Y1}
//   state_e : monitor run-control states
//   sat_inc : saturating counter increment
package sample1_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned REC_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample1_exp_fifo.sv
// Synchronous FIFO holding expected Y1 values for the monitor.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empty the FIFO (pointers and count cleared)
//   push, wdata     : write one 2-bit entry (ignored when full)
//   pop, rdata      : rdata is the head entry; pop discards it (ignored when empty)
//   full, empty     : occupancy flags, registered-state derived
//   count           : current occupancy, 0..DEPTH
// A push into an empty FIFO is only visible on rdata the following cycle.
module sample1_exp_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [1:0]               wdata,
    input  logic                     pop,
    output logic [1:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sample1_monitor.sv
// Run-based checker for a sample1 unit: golden Y1 values are queued through a
// valid/ready port, and each observed sample during a run pops one and compares.
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : IDLE->RUN, DONE->IDLE (ignored in RUN)
//   exp_valid/exp_data/exp_ready: golden Y1 handshake (accepted in IDLE and RUN)
//   obs_valid, A1..A3, Y1       : observed stimulus and response
//   busy, done, pass, underrun  : status
//   smp_cnt, err_cnt, first_err : samples seen, errors (saturating), first bad record
module sample1_monitor
    import sample1_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NUM_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [1:0]       exp_data,
    output logic             exp_ready,
    input  logic             obs_valid,
    input  logic [1:0]       A1,
    input  logic [1:0]       A2,
    input  logic [1:0]       A3,
    input  logic [1:0]       Y1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             underrun,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [REC_W-1:0] first_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  smp_cnt_q, err_cnt_q;
    logic [REC_W-1:0]  first_err_q;
    logic              underrun_q;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic [1:0]        fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic              sample, sample_err, run_start;

    sample1_exp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (exp_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Ready depends only on registered occupancy and state, never on obs_valid.
    assign exp_ready  = (fifo_count < CW'(DEPTH)) && (state_q != StDone);
    assign fifo_push  = exp_valid && exp_ready && !fifo_full;
    assign sample     = (state_q == StRun) && obs_valid;
    assign fifo_pop   = sample && !fifo_empty;
    assign fifo_flush = (state_q == StDone) && start;
    assign run_start  = (state_q == StIdle) && start;

    // An empty FIFO at sample time is an underrun and counts as an error.
    assign sample_err = fifo_empty || (fifo_rdata != Y1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun: begin
                if (sample && (smp_cnt_q == CNT_W'(NUM_SAMPLES - 1))) begin
                    state_d = StDone;
                end
            end
            StDone: if (start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            smp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                smp_cnt_q   <= '0;
                err_cnt_q   <= '0;
                first_err_q <= '0;
                underrun_q  <= 1'b0;
            end else if (sample) begin
                smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                if (sample_err) begin
                    err_cnt_q <= sat_inc(err_cnt_q);
                    // err_cnt never returns to zero within a run, so zero marks
                    // that no error has been recorded yet.
                    if (err_cnt_q == '0) begin
                        first_err_q <= {A1, A2, A3, Y1};
                    end
                end
                if (fifo_empty) begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_cnt_q == '0) && !underrun_q;
    assign underrun  = underrun_q;
    assign smp_cnt   = smp_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_sample1_monitor.sv
module tb_sample1_monitor;

    localparam int DEPTH = 4;
    localparam int NS    = 16;

    logic       clk = 1'b0;
    logic       rst, start, exp_valid, obs_valid;
    logic [1:0] exp_data, a1, a2, a3, y1;
    logic       exp_ready, busy, done, pass, underrun;
    logic [7:0] smp_cnt, err_cnt, first_err;

    int total = 0;
    int bad   = 0;

    // Reference model: run phase (0 idle, 1 running, 2 finished), queue of goldens.
    int         m_phase;
    int         q[$];
    int         m_smp, m_err;
    bit         m_under, m_seen_err;
    logic [7:0] m_first;

    always #5 clk = ~clk;

    sample1_monitor #(
        .DEPTH       (DEPTH),
        .NUM_SAMPLES (NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .exp_valid (exp_valid),
        .exp_data  (exp_data),
        .exp_ready (exp_ready),
        .obs_valid (obs_valid),
        .A1        (a1),
        .A2        (a2),
        .A3        (a3),
        .Y1        (y1),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .underrun  (underrun),
        .smp_cnt   (smp_cnt),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
        chk("done", {31'd0, done}, {31'd0, m_phase == 2});
        chk("pass", {31'd0, pass}, {31'd0, m_phase == 2 && m_err == 0 && !m_under});
        chk("underrun", {31'd0, underrun}, {31'd0, m_under});
        chk("smp_cnt", {24'd0, smp_cnt}, m_smp);
        chk("err_cnt", {24'd0, err_cnt}, m_err);
        chk("first_err", {24'd0, first_err}, {24'd0, m_first});
        chk("exp_ready", {31'd0, exp_ready}, {31'd0, q.size() < DEPTH && m_phase != 2});
    endtask

    task automatic note_err();
        if (!m_seen_err) m_first = {a1, a2, a3, y1};
        m_seen_err = 1'b1;
        if (m_err < 255) m_err++;
    endtask

    // One clock: inputs already driven; model follows the rules using pre-edge state.
    task automatic tick();
        bit room;
        int h;
        room = (q.size() < DEPTH) && (m_phase != 2);
        @(posedge clk);
        #1;
        if (rst) begin
            m_phase = 0; q.delete(); m_smp = 0; m_err = 0;
            m_under = 0; m_seen_err = 0; m_first = 8'h00;
        end else begin
            if (m_phase == 1 && obs_valid) begin
                m_smp++;
                if (q.size() == 0) begin
                    m_under = 1'b1;
                    note_err();
                end else begin
                    h = q.pop_front();
                    if (h != int'(y1)) note_err();
                end
            end
            if (exp_valid && room) q.push_back(int'(exp_data));
            if (m_phase == 0 && start) begin
                m_phase = 1; m_smp = 0; m_err = 0;
                m_under = 0; m_seen_err = 0; m_first = 8'h00;
            end else if (m_phase == 1 && m_smp == NS) begin
                m_phase = 2;
            end else if (m_phase == 2 && start) begin
                m_phase = 0;
                q.delete();
            end
        end
        check_all();
    endtask

    task automatic quiet();
        rst = 0; start = 0; exp_valid = 0; obs_valid = 0;
        exp_data = 0; a1 = 0; a2 = 0; a3 = 0; y1 = 0;
    endtask

    task automatic pulse_start();
        quiet();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic preload(input int n);
        quiet();
        for (int i = 0; i < n; i++) begin
            exp_valid = 1;
            exp_data  = 2'($urandom_range(0, 3));
            tick();
        end
        exp_valid = 0;
    endtask

    // Random traffic until the model has seen `target` samples or the run ends.
    task automatic run_samples(input int target, input int mis_pct, input bit allow_under,
                               input int budget);
        int n = 0;
        while (m_phase == 1 && m_smp < target && n < budget) begin
            exp_valid = 1'($urandom_range(0, 1));
            exp_data  = 2'($urandom_range(0, 3));
            a1 = 2'($urandom_range(0, 3));
            a2 = 2'($urandom_range(0, 3));
            a3 = 2'($urandom_range(0, 3));
            obs_valid = 1'($urandom_range(0, 1));
            if (!allow_under && q.size() == 0) obs_valid = 0;
            if (q.size() > 0 && $urandom_range(0, 99) >= mis_pct) y1 = 2'(q[0]);
            else y1 = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        quiet();
    endtask

    initial begin
        m_phase = 0; m_smp = 0; m_err = 0; m_under = 0; m_seen_err = 0; m_first = 0;
        quiet();
        rst = 1;
        tick();
        rst = 0;
        chk("reset_ready", {31'd0, exp_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Preload 16 offers in IDLE; only DEPTH fit.
        preload(16);
        chk("preload_ready_low", {31'd0, exp_ready}, 32'd0);
        pulse_start();
        run_samples(NS, 0, 0, 400);
        chk("match_done", {31'd0, done}, 32'd1);
        chk("match_pass", {31'd0, pass}, 32'd1);
        chk("match_err", {24'd0, err_cnt}, 32'd0);
        chk("match_smp", {24'd0, smp_cnt}, 32'd16);
        pulse_start();

        // Second sample mismatches: expected 3, observed Y1=1 with A=1,3,0.
        quiet();
        for (int i = 0; i < 4; i++) begin
            exp_valid = 1;
            exp_data  = (i == 1) ? 2'd3 : 2'($urandom_range(0, 3));
            tick();
        end
        pulse_start();
        obs_valid = 1; y1 = 2'(q[0]);
        tick();
        obs_valid = 1; a1 = 2'd1; a2 = 2'd3; a3 = 2'd0; y1 = 2'd1;
        tick();
        run_samples(NS, 0, 0, 400);
        chk("mis_err", {24'd0, err_cnt}, 32'd1);
        chk("mis_first", {24'd0, first_err}, 32'h71);
        chk("mis_pass", {31'd0, pass}, 32'd0);
        pulse_start();

        // Empty FIFO: push and sample together -> underrun, value kept for next sample.
        pulse_start();
        exp_valid = 1; exp_data = 2'd2; obs_valid = 1; y1 = 2'd2;
        tick();
        chk("under_flag", {31'd0, underrun}, 32'd1);
        chk("under_err", {24'd0, err_cnt}, 32'd1);
        quiet();
        obs_valid = 1; y1 = 2'd2;
        tick();
        chk("under_next_err", {24'd0, err_cnt}, 32'd1);
        chk("under_next_smp", {24'd0, smp_cnt}, 32'd2);
        run_samples(NS, 0, 0, 400);
        chk("under_done", {31'd0, done}, 32'd1);
        pulse_start();

        // Full FIFO: offer and sample together -> no push, occupancy 3.
        preload(DEPTH);
        pulse_start();
        chk("full_ready_low", {31'd0, exp_ready}, 32'd0);
        exp_valid = 1; exp_data = 2'd1; obs_valid = 1; y1 = 2'(q[0]);
        tick();
        chk("full_ready_back", {31'd0, exp_ready}, 32'd1);
        chk("full_occupancy", q.size(), 32'd3);
        run_samples(NS, 15, 1, 400);
        chk("full_done", {31'd0, done}, 32'd1);
        pulse_start();

        // Reset mid-run after sample 5, then a clean run.
        preload(DEPTH);
        pulse_start();
        run_samples(5, 0, 0, 200);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_smp", {24'd0, smp_cnt}, 32'd0);
        chk("rst_ready", {31'd0, exp_ready}, 32'd1);
        pulse_start();
        run_samples(NS, 0, 0, 400);
        chk("rst_rerun_pass", {31'd0, pass}, 32'd1);

        // Extra samples in DONE are ignored; start flushes back to IDLE.
        for (int i = 0; i < 4; i++) begin
            obs_valid = 1; exp_valid = 1; y1 = 2'($urandom_range(0, 3));
            tick();
        end
        chk("extra_smp", {24'd0, smp_cnt}, 32'd16);
        pulse_start();
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_ready", {31'd0, exp_ready}, 32'd1);
        pulse_start();
        obs_valid = 1; y1 = 2'd0;
        tick();
        chk("flush_empty_under", {31'd0, underrun}, 32'd1);
        run_samples(NS, 20, 1, 400);
        pulse_start();

        // Random runs with mismatches and underruns.
        for (int r = 0; r < 3; r++) begin
            preload($urandom_range(0, 6));
            pulse_start();
            run_samples(NS, 25, 1, 400);
            chk("rand_done", {31'd0, done}, 32'd1);
            pulse_start();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
